// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared FSM encoding and instruction field positions for the
//               fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

    localparam int BUNDLE_SIZE = 4;
    localparam int BRANCH_BIT  = 9;
    localparam int OFFSET_MSB  = 15;

    typedef logic [1:0] state_t;

    localparam logic [1:0] S_BOOT     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : I-cache, predictor, redirect and decode signals of the fetch
//               sequencer; master is the sequencer, slave is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     i_Stall;
    logic                     o_Fetch_Req;
    logic [ADDRESS_WIDTH-1:0] o_Fetch_PC;
    logic                     i_Fetch_Ready;
    logic                     i_Bundle_Valid;
    logic [ADDRESS_WIDTH-1:0] i_Bundle_PC;
    logic [DATA_WIDTH-1:0]    i_Isn1;
    logic [DATA_WIDTH-1:0]    i_Isn2;
    logic [DATA_WIDTH-1:0]    i_Isn3;
    logic [DATA_WIDTH-1:0]    i_Isn4;
    logic                     o_Isbranch;
    logic [ADDRESS_WIDTH-1:0] o_Branch_Address;
    logic                     i_Predict_Taken;
    logic                     i_Redirect;
    logic [ADDRESS_WIDTH-1:0] i_Redirect_PC;
    logic                     o_Isn_Valid;
    logic [DATA_WIDTH-1:0]    o_Isn;
    logic [ADDRESS_WIDTH-1:0] o_Isn_PC;

    modport master (
        input  i_Stall, i_Fetch_Ready, i_Bundle_Valid, i_Bundle_PC,
               i_Isn1, i_Isn2, i_Isn3, i_Isn4, i_Predict_Taken,
               i_Redirect, i_Redirect_PC,
        output o_Fetch_Req, o_Fetch_PC, o_Isbranch, o_Branch_Address,
               o_Isn_Valid, o_Isn, o_Isn_PC
    );

    modport slave (
        output i_Stall, i_Fetch_Ready, i_Bundle_Valid, i_Bundle_PC,
               i_Isn1, i_Isn2, i_Isn3, i_Isn4, i_Predict_Taken,
               i_Redirect, i_Redirect_PC,
        input  o_Fetch_Req, o_Fetch_PC, o_Isbranch, o_Branch_Address,
               o_Isn_Valid, o_Isn, o_Isn_PC
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_bundle_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_bundle_fifo
// Description : Small FIFO of returned bundles with synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer_bundle_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 160,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             i_Clk,
    input  wire logic             i_Reset_n,
    input  wire logic             i_Flush,
    input  wire logic             i_Push,
    input  wire logic [WIDTH-1:0] i_Data,
    input  wire logic             i_Pop,
    output logic      [WIDTH-1:0] o_Data,
    output logic      [CNT_W-1:0] o_Count,
    output logic                  o_Full,
    output logic                  o_Empty
);
    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == C_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_Empty = (count_q == '0);
    assign o_Full  = (count_q == C_DEPTH);
    assign o_Count = count_q;
    assign o_Data  = mem_q[rd_ptr_q];

    assign w_do_pop  = i_Pop && !o_Empty;
    assign w_do_push = i_Push && (!o_Full || w_do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) begin
                mem_d[wr_ptr_q] = i_Data;
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end
            if (w_do_pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            if (w_do_push && !w_do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetch PC generation, bundle buffering and single-instruction
//               issue with predicted-taken and redirect squashing.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter int                       BUF_DEPTH     = 2
) (
    input wire logic          i_Clk,
    input wire logic          i_Reset_n,
    fetch_sequencer_if.master bus
);
    localparam int               ENTRY_W = ADDRESS_WIDTH + BUNDLE_SIZE * DATA_WIDTH;
    localparam int               CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam int               OFF_W   = OFFSET_MSB + 1;
    localparam logic [CNT_W:0]   C_CAP   = (CNT_W + 1)'(BUF_DEPTH);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0] expect_pc_q, expect_pc_d;
    logic [CNT_W-1:0]         outstanding_q, outstanding_d;
    logic [1:0]               slot_q, slot_d;
    logic                     isn_valid_q, isn_valid_d;
    logic [DATA_WIDTH-1:0]    isn_q, isn_d;
    logic [ADDRESS_WIDTH-1:0] isn_pc_q, isn_pc_d;

    logic [ENTRY_W-1:0]       w_head;
    logic [CNT_W-1:0]         w_count;
    logic                     w_full;
    logic                     w_empty;
    logic [ADDRESS_WIDTH-1:0] w_head_pc;
    logic [DATA_WIDTH-1:0]    w_head_isn;
    logic [ADDRESS_WIDTH-1:0] w_branch_address;
    logic [ADDRESS_WIDTH-1:0] w_offset_ext;
    logic [ADDRESS_WIDTH-1:0] w_target;
    logic                     w_isbranch;
    logic                     w_fetch_req;
    logic                     w_issue;
    logic                     w_taken;
    logic                     w_flush;
    logic                     w_fetch_fire;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_ret_dec;

    fetch_sequencer_bundle_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_bundle_fifo (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .i_Flush   (w_flush),
        .i_Push    (w_push),
        .i_Data    ({bus.i_Bundle_PC, bus.i_Isn4, bus.i_Isn3, bus.i_Isn2, bus.i_Isn1}),
        .i_Pop     (w_pop),
        .o_Data    (w_head),
        .o_Count   (w_count),
        .o_Full    (w_full),
        .o_Empty   (w_empty)
    );

    assign w_head_pc = w_head[ENTRY_W-1 -: ADDRESS_WIDTH];

    always_comb begin
        w_head_isn = w_head[DATA_WIDTH-1:0];
        case (slot_q)
            2'd1:    w_head_isn = w_head[2*DATA_WIDTH-1 -: DATA_WIDTH];
            2'd2:    w_head_isn = w_head[3*DATA_WIDTH-1 -: DATA_WIDTH];
            2'd3:    w_head_isn = w_head[4*DATA_WIDTH-1 -: DATA_WIDTH];
            default: w_head_isn = w_head[DATA_WIDTH-1:0];
        endcase
    end

    assign w_branch_address = w_head_pc + {{(ADDRESS_WIDTH-2){1'b0}}, slot_q};
    assign w_offset_ext     = {{(ADDRESS_WIDTH-OFF_W){w_head_isn[OFFSET_MSB]}},
                               w_head_isn[OFFSET_MSB:0]};
    assign w_target         = w_branch_address + ADDRESS_WIDTH'(1) + w_offset_ext;

    assign w_isbranch  = !w_empty && w_head_isn[BRANCH_BIT];
    assign w_fetch_req = (state_q == S_RUN) &&
                         (({1'b0, outstanding_q} + {1'b0, w_count}) < C_CAP);

    // Redirect outranks everything, so it also suppresses the issue itself.
    assign w_issue      = !w_empty && (state_q == S_RUN) && !bus.i_Stall && !bus.i_Redirect;
    assign w_taken      = w_issue && w_isbranch && bus.i_Predict_Taken;
    assign w_flush      = bus.i_Redirect || w_taken;
    assign w_fetch_fire = w_fetch_req && bus.i_Fetch_Ready && !w_flush;
    // Returns carrying any other PC are leftovers from before a flush.
    assign w_accept     = bus.i_Bundle_Valid && (bus.i_Bundle_PC == expect_pc_q) && !w_flush;
    assign w_pop        = w_issue && (slot_q == 2'd3);
    assign w_push       = w_accept && (!w_full || w_pop);
    assign w_ret_dec    = bus.i_Bundle_Valid && (outstanding_q != '0);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        expect_pc_d   = expect_pc_q;
        outstanding_d = outstanding_q;
        slot_d        = slot_q;
        isn_valid_d   = isn_valid_q;
        isn_d         = isn_q;
        isn_pc_d      = isn_pc_q;

        if (w_fetch_fire && !w_ret_dec) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!w_fetch_fire && w_ret_dec) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        if (w_fetch_fire) begin
            fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(BUNDLE_SIZE);
        end
        if (w_accept) begin
            expect_pc_d = expect_pc_q + ADDRESS_WIDTH'(BUNDLE_SIZE);
        end

        if (w_issue) begin
            isn_valid_d = 1'b1;
            isn_d       = w_head_isn;
            isn_pc_d    = w_branch_address;
            slot_d      = slot_q + 2'd1;
        end else if (!bus.i_Stall) begin
            isn_valid_d = 1'b0;
        end

        case (state_q)
            S_BOOT:     state_d = S_RUN;
            S_REDIRECT: state_d = S_RUN;
            default:    state_d = w_taken ? S_REDIRECT : S_RUN;
        endcase

        if (bus.i_Redirect) begin
            isn_valid_d = 1'b0;
            fetch_pc_d  = bus.i_Redirect_PC;
            expect_pc_d = bus.i_Redirect_PC;
            slot_d      = 2'd0;
            state_d     = S_REDIRECT;
        end else if (w_taken) begin
            fetch_pc_d  = w_target;
            expect_pc_d = w_target;
            slot_d      = 2'd0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q       <= S_BOOT;
            fetch_pc_q    <= RESET_PC;
            expect_pc_q   <= RESET_PC;
            outstanding_q <= '0;
            slot_q        <= 2'd0;
            isn_valid_q   <= 1'b0;
            isn_q         <= '0;
            isn_pc_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            expect_pc_q   <= expect_pc_d;
            outstanding_q <= outstanding_d;
            slot_q        <= slot_d;
            isn_valid_q   <= isn_valid_d;
            isn_q         <= isn_d;
            isn_pc_q      <= isn_pc_d;
        end
    end

    assign bus.o_Fetch_Req      = w_fetch_req;
    assign bus.o_Fetch_PC       = fetch_pc_q;
    assign bus.o_Isbranch       = w_isbranch;
    assign bus.o_Branch_Address = w_branch_address;
    assign bus.o_Isn_Valid      = isn_valid_q;
    assign bus.o_Isn            = isn_q;
    assign bus.o_Isn_PC         = isn_pc_q;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front-end controller between the I-cache bundle port and decode. It generates word-addressed fetch PCs, buffers returned 4-instruction bundles, and issues one instruction per cycle to decode. It presents each head instruction to the branch predictor and squashes younger work on a predicted-taken branch or an execute-stage redirect.

Parameters:
ADDRESS_WIDTH, 32, PC width; word-addressed, so next instruction is PC+1.
DATA_WIDTH, 32, instruction width.
RESET_PC, 0, first fetch address after reset.
BUF_DEPTH, 2, bundle buffer entries; also the cap on outstanding plus buffered bundles.

Ports:
i_Clk  in  1  clock, rising edge.
i_Reset_n  in  1  reset; asynchronous and active-low.
i_Stall  in  1  decode stall; freezes issue.
o_Fetch_Req  out  1  fetch request valid.
o_Fetch_PC  out  ADDRESS_WIDTH  bundle address requested.
i_Fetch_Ready  in  1  I-cache accepts the request this cycle.
i_Bundle_Valid  in  1  returned bundle valid; bundles return in order.
i_Bundle_PC  in  ADDRESS_WIDTH  PC of i_Isn1.
i_Isn1..i_Isn4  in  DATA_WIDTH each  bundle instructions; bit 9 marks a branch; [15:0] is the signed offset.
o_Isbranch  out  1  head instruction is a valid branch (combinational).
o_Branch_Address  out  ADDRESS_WIDTH  PC of the head instruction (combinational).
i_Predict_Taken  in  1  predictor response for o_Branch_Address, same cycle.
i_Redirect  in  1  execute-stage mispredict or jump.
i_Redirect_PC  in  ADDRESS_WIDTH  corrected PC.
o_Isn_Valid  out  1  registered issue valid.
o_Isn  out  DATA_WIDTH  registered issued instruction.
o_Isn_PC  out  ADDRESS_WIDTH  registered PC of o_Isn.

Behaviour:
- Reset values:
  - State = S_BOOT.
  - o_Fetch_PC = r_Expect_PC = RESET_PC.
  - Outstanding counter, buffer count, head slot = 0.
  - o_Isn_Valid = 0; o_Isn = 0; o_Isn_PC = 0.
  - o_Fetch_Req = 0.
- Reset asserted mid-operation discards all buffered and outstanding bundles immediately.
- FSM:
  - S_BOOT: one cycle, then S_RUN.
  - S_RUN: normal operation.
  - S_REDIRECT: one cycle. o_Fetch_Req = 0 and no issue; then returns to S_RUN.
- Fetch:
  - o_Fetch_Req = (state == S_RUN) && (outstanding + count < BUF_DEPTH).
  - On o_Fetch_Req && i_Fetch_Ready: outstanding++, o_Fetch_PC += 4.
- Return:
  - Every i_Bundle_Valid decrements outstanding.
  - Accepted into the buffer only if i_Bundle_PC == r_Expect_PC; then r_Expect_PC += 4.
  - A mismatch is a stale post-flush bundle and is silently dropped.
  - An accept and a pop in the same cycle are legal; count is unchanged.
- Issue, when head valid, state == S_RUN, and !i_Stall:
  - o_Isn <= head slot instruction; o_Isn_PC <= head PC + slot; o_Isn_Valid <= 1.
  - Slot advances; slot 3 wraps to 0 and pops the head bundle.
  - With nothing to issue and no stall: o_Isn_Valid <= 0.
- i_Stall holds o_Isn, o_Isn_PC and o_Isn_Valid unchanged; fetch and return still proceed.
- o_Isbranch = head valid && head instruction bit 9, independent of stall.
- Predicted taken: issue occurs && o_Isbranch && i_Predict_Taken.
  - The branch itself issues.
  - Target = o_Branch_Address + 1 + sign_extend(insn[15:0]), truncated to ADDRESS_WIDTH (wraps).
  - Buffer is flushed and slot cleared.
  - o_Fetch_PC and r_Expect_PC are loaded with the target.
  - Next state is S_REDIRECT.
- i_Redirect, in any state except reset, has top priority over issue, predicted-taken handling and stall:
  - Flush buffer; o_Isn_Valid <= 0.
  - o_Fetch_PC = r_Expect_PC = i_Redirect_PC.
  - Next state is S_REDIRECT.
- Outstanding is not cleared on any flush; stale returns drain via the PC mismatch rule.
- A fetch handshake in the flush cycle does not count; outstanding is not incremented for it.
- Full buffer: no request is issued, so no overflow is possible.
- Empty buffer: no issue, and o_Isbranch = 0.

Decomposition:
- Shared package: FSM state encoding (S_BOOT, S_RUN, S_REDIRECT), BUNDLE_SIZE = 4, BRANCH_BIT = 9, OFFSET_MSB = 15.
- One sub-module: bundle_fifo, a BUF_DEPTH x (ADDRESS_WIDTH + 4*DATA_WIDTH) FIFO with synchronous flush, push, pop, full and empty.

Test Plan:
- Reset release, i_Fetch_Ready = 1, bundles with PC 0, 4 and no branches -> fetch PCs 0, 4, 8; o_Isn_PC issues 0, 1, ... 7 on consecutive cycles.
- Bundle at PC 8, i_Isn2 bit9 = 1, offset 0x0010, i_Predict_Taken = 1 -> PC 9 issues; target 26 is fetched after one S_REDIRECT cycle; PCs 10 and 11 are never issued.
- Offset 0xFFFE on a branch at PC 4, predicted taken -> target 3; with the branch at PC 0 and offset 0xFFFE -> target 0xFFFFFFFF (wrap).
- i_Redirect to 100 with two bundles outstanding -> both stale returns (PCs 12 and 16) are dropped, outstanding returns to 0, next issued PC = 100.
- i_Stall held 3 cycles -> o_Isn/o_Isn_PC are held; the buffer fills to BUF_DEPTH and o_Fetch_Req deasserts; after release, issue resumes with no lost PC.
- Reset asserted mid-stream with buffer full -> o_Isn_Valid = 0 and o_Fetch_PC = RESET_PC immediately.
